alu_sequencer: RTL

- Multi-cycle initiator that drives the combinational Alu block (mode, a, b, flags in; out, outFlags back).
- Fetches operands from the register file and sequences multi-pass operations: word INCW/DECW as low byte then high byte, and DA as low-nibble pass then high-nibble pass.
- Writes results and flags back.
- Sits between the instruction decoder and the register file / FLAGS register.

---
 rtl/alu_sequencer_if.sv | 56 +++++
 rtl/alu_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Bundle of the decoder command, register-file, Alu and FLAGS
//                signals around the Alu sequencer.
//                master = sequencer side, slave = environment side.
//  Ports       : start/op/src_sel/dst_addr/src_addr/imm/flags_in (command)
//                rf_raddr/rf_rdata/rf_waddr/rf_wdata/rf_we   (register file)
//                alu_mode/alu_a/alu_b/alu_flags/alu_out/alu_outflags (Alu)
//                flags_out/flags_we (FLAGS), busy/done (status)
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [4:0]        op;
    logic [1:0]        src_sel;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] flags_in;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [4:0]        alu_mode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_flags;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] alu_outflags;
    logic [DATA_W-1:0] flags_out;
    logic              flags_we;
    logic              busy;
    logic              done;

    modport master (
        input  start, op, src_sel, dst_addr, src_addr, imm, flags_in,
        input  rf_rdata, alu_out, alu_outflags,
        output rf_raddr, rf_waddr, rf_wdata, rf_we,
        output alu_mode, alu_a, alu_b, alu_flags,
        output flags_out, flags_we, busy, done
    );

    modport slave (
        output start, op, src_sel, dst_addr, src_addr, imm, flags_in,
        output rf_rdata, alu_out, alu_outflags,
        input  rf_raddr, rf_waddr, rf_wdata, rf_we,
        input  alu_mode, alu_a, alu_b, alu_flags,
        input  flags_out, flags_we, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle initiator for the combinational 8-bit Alu.
//                Reads operands from the register file, runs single-pass byte
//                ops, two-pass DA (low nibble then high nibble) and word
//                INCW/DECW (low byte then high byte), and writes the result
//                and FLAGS back.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                bus   - alu_sequencer_if.master (command, register file,
//                        Alu, FLAGS and status signals)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    alu_sequencer_if.master     bus
);
    // Alu mode codes shared with the Alu block
    localparam logic [4:0] C_OP_TCM  = 5'h06;
    localparam logic [4:0] C_OP_TM   = 5'h07;
    localparam logic [4:0] C_OP_CP   = 5'h08;
    localparam logic [4:0] C_OP_INC  = 5'h0A;
    localparam logic [4:0] C_OP_DEC  = 5'h0B;
    localparam logic [4:0] C_OP_DA   = 5'h0C;
    localparam logic [4:0] C_OP_DA_H = 5'h0D;
    localparam logic [4:0] C_OP_INCW = 5'h0E;
    localparam logic [4:0] C_OP_DECW = 5'h0F;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_DST, S_RD_SRC, S_EXEC, S_RD_LO, S_RD_HI,
        S_EXEC_LO, S_EXEC_HI, S_EXEC_DA2, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        op_q, op_d;
    logic [1:0]        src_sel_q, src_sel_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] flags_q, flags_d;
    logic [DATA_W-1:0] a_q, a_d;          // first operand / captured low byte
    logic [DATA_W-1:0] hi_q, hi_d;        // captured high byte (word ops)
    logic [DATA_W-1:0] res_q, res_d;      // DA first-pass result / new low byte
    logic [DATA_W-1:0] rflags_q, rflags_d; // DA first-pass flags

    logic              w_is_word_in;
    logic              w_is_da;
    logic              w_no_wb;
    logic              w_use_src;
    logic              w_use_imm;
    logic [ADDR_W-1:0] w_lo_addr;
    logic [ADDR_W-1:0] w_hi_addr;

    assign w_is_word_in = (bus.op == C_OP_INCW) || (bus.op == C_OP_DECW);
    assign w_is_da      = (op_q == C_OP_DA);
    assign w_no_wb      = (op_q == C_OP_CP) || (op_q == C_OP_TM) || (op_q == C_OP_TCM);
    // DA always runs as a unary op regardless of src_sel
    assign w_use_src    = (src_sel_q == 2'd1) && !w_is_da;
    assign w_use_imm    = (src_sel_q == 2'd2) && !w_is_da;
    // Word pairs: even address holds the high byte
    assign w_lo_addr    = {dst_q[ADDR_W-1:1], 1'b1};
    assign w_hi_addr    = {dst_q[ADDR_W-1:1], 1'b0};

    // Read address is registered so it holds its value outside read states
    assign bus.rf_raddr = raddr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            src_sel_q <= '0;
            dst_q     <= '0;
            src_q     <= '0;
            raddr_q   <= '0;
            imm_q     <= '0;
            flags_q   <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            res_q     <= '0;
            rflags_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_sel_q <= src_sel_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            raddr_q   <= raddr_d;
            imm_q     <= imm_d;
            flags_q   <= flags_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            res_q     <= res_d;
            rflags_q  <= rflags_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src_sel_d     = src_sel_q;
        dst_d         = dst_q;
        src_d         = src_q;
        raddr_d       = raddr_q;
        imm_d         = imm_q;
        flags_d       = flags_q;
        a_d           = a_q;
        hi_d          = hi_q;
        res_d         = res_q;
        rflags_d      = rflags_q;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.rf_we     = 1'b0;
        bus.alu_mode  = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_flags = '0;
        bus.flags_out = '0;
        bus.flags_we  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    src_sel_d = bus.src_sel;
                    dst_d     = bus.dst_addr;
                    src_d     = bus.src_addr;
                    imm_d     = bus.imm;
                    flags_d   = bus.flags_in;
                    if (w_is_word_in) begin
                        raddr_d = {bus.dst_addr[ADDR_W-1:1], 1'b1};
                        state_d = S_RD_LO;
                    end else begin
                        raddr_d = bus.dst_addr;
                        state_d = S_RD_DST;
                    end
                end
            end
            S_RD_DST: begin
                bus.busy = 1'b1;
                if (w_use_src) begin
                    raddr_d = src_q;
                    state_d = S_RD_SRC;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_RD_SRC: begin
                bus.busy = 1'b1;
                a_d      = bus.rf_rdata;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                bus.busy      = 1'b1;
                bus.alu_mode  = op_q;
                bus.alu_flags = flags_q;
                // With a register source, A was captured last cycle and the
                // source byte is arriving now; otherwise A is arriving now.
                if (w_use_src) begin
                    bus.alu_a = a_q;
                    bus.alu_b = bus.rf_rdata;
                end else begin
                    bus.alu_a = bus.rf_rdata;
                    bus.alu_b = w_use_imm ? imm_q : '0;
                end
                if (w_is_da) begin
                    res_d    = bus.alu_out;
                    rflags_d = bus.alu_outflags;
                    state_d  = S_EXEC_DA2;
                end else begin
                    bus.flags_out = bus.alu_outflags;
                    bus.flags_we  = 1'b1;
                    if (!w_no_wb) begin
                        bus.rf_we    = 1'b1;
                        bus.rf_waddr = dst_q;
                        bus.rf_wdata = bus.alu_out;
                    end
                    state_d = S_DONE;
                end
            end
            S_EXEC_DA2: begin
                bus.busy      = 1'b1;
                bus.alu_mode  = C_OP_DA_H;
                bus.alu_a     = res_q;
                bus.alu_flags = rflags_q;
                bus.rf_we     = 1'b1;
                bus.rf_waddr  = dst_q;
                bus.rf_wdata  = bus.alu_out;
                bus.flags_out = bus.alu_outflags;
                bus.flags_we  = 1'b1;
                state_d       = S_DONE;
            end
            S_RD_LO: begin
                bus.busy = 1'b1;
                raddr_d  = w_hi_addr;
                state_d  = S_RD_HI;
            end
            S_RD_HI: begin
                bus.busy = 1'b1;
                a_d      = bus.rf_rdata;
                state_d  = S_EXEC_LO;
            end
            S_EXEC_LO: begin
                bus.busy      = 1'b1;
                bus.alu_mode  = (op_q == C_OP_INCW) ? C_OP_INC : C_OP_DEC;
                bus.alu_a     = a_q;
                bus.alu_flags = flags_q;
                bus.rf_we     = 1'b1;
                bus.rf_waddr  = w_lo_addr;
                bus.rf_wdata  = bus.alu_out;
                res_d         = bus.alu_out;
                hi_d          = bus.rf_rdata;
                state_d       = S_EXEC_HI;
            end
            S_EXEC_HI: begin
                // The word-mode Alu pass derives carry/borrow and 16-bit Z
                // from the new low byte supplied on b.
                bus.busy      = 1'b1;
                bus.alu_mode  = op_q;
                bus.alu_a     = hi_q;
                bus.alu_b     = res_q;
                bus.alu_flags = flags_q;
                bus.rf_we     = 1'b1;
                bus.rf_waddr  = w_hi_addr;
                bus.rf_wdata  = bus.alu_out;
                bus.flags_out = bus.alu_outflags;
                bus.flags_we  = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire
